// File: rtl/round_sequencer_pkg.sv
// Shared types for the round sequencer: phase codes, field widths and the
// per-level round budget (clamped time, rescue target).
package round_sequencer_pkg;

  localparam int TIME_W = 8;
  localparam int CNT_W  = 5;

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_LOAD   = 3'd1,
    PH_PLAY   = 3'd2,
    PH_RESULT = 3'd3,
    PH_SETTLE = 3'd4,
    PH_SHOW   = 3'd5,
    PH_OVER   = 3'd6,
    PH_WON    = 3'd7
  } phase_e;

  typedef struct packed {
    logic [TIME_W-1:0] secs;
    logic [CNT_W-1:0]  target;
  } budget_t;

  // Time shrinks with level in 9-bit signed space so low budgets can go
  // negative before the floor is applied; target wraps at 5 bits.
  function automatic budget_t round_budget(
    input logic [CNT_W-1:0]  level,
    input logic [TIME_W-1:0] base_time,
    input logic [TIME_W-1:0] time_step,
    input logic [TIME_W-1:0] min_time,
    input logic [CNT_W-1:0]  base_target
  );
    logic signed [8:0] lvl_m1;
    logic signed [8:0] raw_t;
    logic signed [8:0] floor_t;
    budget_t b;
    lvl_m1   = $signed({4'b0000, level}) - 9'sd1;
    raw_t    = $signed({1'b0, base_time}) - lvl_m1 * $signed({1'b0, time_step});
    floor_t  = $signed({1'b0, min_time});
    b.secs   = (raw_t < floor_t) ? min_time : raw_t[TIME_W-1:0];
    b.target = base_target + level - 5'd1;
    return b;
  endfunction

endpackage

// File: rtl/round_sequencer_timer.sv
// round_timer: seconds-remaining counter for one round, loaded at round start
// and decremented on qualified ticks; flags the tick that would expire it.
module round_timer
  import round_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [TIME_W-1:0] load_val,
  input  logic              tick,
  input  logic              dec,
  output logic [TIME_W-1:0] time_left,
  output logic              expire
);

  logic [TIME_W-1:0] time_left_d, time_left_q;

  always_comb begin
    time_left_d = time_left_q;
    if (load) begin
      time_left_d = load_val;
    end else if (dec && (time_left_q != '0)) begin
      time_left_d = time_left_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) time_left_q <= '0;
    else          time_left_q <= time_left_d;
  end

  assign time_left = time_left_q;
  assign expire    = tick && (time_left_q == TIME_W'(1));

endmodule

// File: rtl/round_sequencer.sv
// round_sequencer: game-flow FSM that runs one round at a time and drives the
// life/level tracker. Define ROUND_PAUSE_EN to build the in-round pause toggle.
module round_sequencer
  import round_sequencer_pkg::*;
#(
  parameter int          BASE_TIME   = 30,
  parameter int          TIME_STEP   = 2,
  parameter int          MIN_TIME    = 10,
  parameter int          BASE_TARGET = 2,
  parameter int unsigned HOLD_CYCLES = 50000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              tick,
  input  logic              rescue,
  input  logic              hit,
  input  logic              pause,
  input  logic [CNT_W-1:0]  level_i,
  input  logic [CNT_W-1:0]  life_i,
  input  logic              game_over_i,
  input  logic              game_won_i,
  output logic              finish,
  output logic              win,
  output logic              tracker_rst_n,
  output logic [2:0]        phase,
  output logic [TIME_W-1:0] time_left,
  output logic [CNT_W-1:0]  rescued,
  output logic [CNT_W-1:0]  target
);

  phase_e            phase_q, phase_d;
  logic              finish_q, finish_d, win_q, win_d;
  logic              trk_rst_n_q, trk_rst_n_d;
  logic [CNT_W-1:0]  rescued_q, rescued_d, target_q, target_d;
  logic [31:0]       hold_q, hold_d;
  logic              paused, play_act, tick_g, rescue_g, hit_g;
  logic              timer_load, timer_dec, expire, rescue_done;
  logic [TIME_W-1:0] time_left_w;
  budget_t           budget;
  logic              unused_ok;

  assign budget = round_budget(level_i, TIME_W'(BASE_TIME), TIME_W'(TIME_STEP),
                               TIME_W'(MIN_TIME), CNT_W'(BASE_TARGET));

`ifdef ROUND_PAUSE_EN
  logic paused_q, paused_d;
  assign paused    = paused_q;
  assign unused_ok = ^life_i;

  always_comb begin
    paused_d = paused_q;
    if ((phase_q == PH_PLAY) && pause) paused_d = ~paused_q;
    if (phase_d != PH_PLAY)            paused_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) paused_q <= 1'b0;
    else          paused_q <= paused_d;
  end
`else
  assign paused    = 1'b0;
  assign unused_ok = ^{life_i, pause};
`endif

  assign play_act    = (phase_q == PH_PLAY) && !paused;
  assign tick_g      = tick && play_act;
  assign rescue_g    = rescue && play_act;
  assign hit_g       = hit && play_act;
  assign rescue_done = ({1'b0, rescued_q} + 6'd1) == {1'b0, target_q};

  round_timer u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (timer_load),
    .load_val  (budget.secs),
    .tick      (tick_g),
    .dec       (timer_dec),
    .time_left (time_left_w),
    .expire    (expire)
  );

  always_comb begin
    phase_d     = phase_q;
    finish_d    = 1'b0;
    win_d       = 1'b0;
    trk_rst_n_d = 1'b1;
    rescued_d   = rescued_q;
    target_d    = target_q;
    hold_d      = hold_q;
    timer_load  = 1'b0;
    timer_dec   = 1'b0;
    case (phase_q)
      PH_IDLE, PH_OVER, PH_WON: begin
        if (start) begin
          phase_d     = PH_LOAD;
          trk_rst_n_d = 1'b0;
        end
      end
      PH_LOAD: begin
        timer_load = 1'b1;
        target_d   = budget.target;
        rescued_d  = '0;
        phase_d    = PH_PLAY;
      end
      PH_PLAY: begin
        // A hit beats a completing rescue, which beats a timeout.
        if (hit_g) begin
          phase_d  = PH_RESULT;
          finish_d = 1'b1;
        end else if (rescue_g && rescue_done) begin
          phase_d  = PH_RESULT;
          finish_d = 1'b1;
          win_d    = 1'b1;
        end else if (expire) begin
          phase_d  = PH_RESULT;
          finish_d = 1'b1;
        end else begin
          if (rescue_g && (rescued_q != '1)) rescued_d = rescued_q + 1'b1;
          timer_dec = tick_g;
        end
      end
      PH_RESULT: phase_d = PH_SETTLE;
      PH_SETTLE: begin
        hold_d  = '0;
        phase_d = PH_SHOW;
      end
      PH_SHOW: begin
        if (hold_q == 32'(HOLD_CYCLES - 1)) begin
          hold_d = '0;
          if (game_won_i)       phase_d = PH_WON;
          else if (game_over_i) phase_d = PH_OVER;
          else                  phase_d = PH_LOAD;
        end else begin
          hold_d = hold_q + 32'd1;
        end
      end
      default: phase_d = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase_q     <= PH_IDLE;
      finish_q    <= 1'b0;
      win_q       <= 1'b0;
      trk_rst_n_q <= 1'b0;
      rescued_q   <= '0;
      target_q    <= '0;
      hold_q      <= '0;
    end else begin
      phase_q     <= phase_d;
      finish_q    <= finish_d;
      win_q       <= win_d;
      trk_rst_n_q <= trk_rst_n_d;
      rescued_q   <= rescued_d;
      target_q    <= target_d;
      hold_q      <= hold_d;
    end
  end

  assign finish        = finish_q;
  assign win           = win_q;
  assign tracker_rst_n = trk_rst_n_q;
  assign phase         = phase_q;
  assign time_left     = time_left_w;
  assign rescued       = rescued_q;
  assign target        = target_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer with an attached life/level tracker model and a
// scoreboard of expected round loads and round results.
module tb_round_sequencer;
  import round_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset_n, start, tick, rescue, hit, pause;
  logic finish, win, tracker_rst_n;
  logic [2:0] phase;
  logic [7:0] time_left;
  logic [4:0] rescued, target;
  logic [4:0] m_lvl, m_life;
  logic       m_over, m_won;

  always #5 clk = ~clk;

  round_sequencer #(.HOLD_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .tick(tick), .rescue(rescue),
    .hit(hit), .pause(pause), .level_i(m_lvl), .life_i(m_life),
    .game_over_i(m_over), .game_won_i(m_won), .finish(finish), .win(win),
    .tracker_rst_n(tracker_rst_n), .phase(phase), .time_left(time_left),
    .rescued(rescued), .target(target)
  );

  // Tracker: wins advance level (winning level 10 ends the game), losses cost a life.
  always @(posedge clk) begin
    if (!tracker_rst_n) begin
      m_lvl <= 5'd1; m_life <= 5'd3; m_over <= 1'b0; m_won <= 1'b0;
    end else if (finish) begin
      if (win) begin
        m_lvl <= m_lvl + 5'd1;
        if (m_lvl == 5'd10) m_won <= 1'b1;
      end else begin
        m_life <= m_life - 5'd1;
        if (m_life == 5'd1) m_over <= 1'b1;
      end
    end
  end

  typedef struct {
    bit         is_fin;
    logic [7:0] tl;
    logic [4:0] tg;
    bit         w;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int passes = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: actual %0d required %0d", nm, act, req);
  endfunction

  function automatic void push_load(input int tl, input int tg);
    exp_t e;
    e.is_fin = 1'b0; e.tl = 8'(tl); e.tg = 5'(tg); e.w = 1'b0;
    sbq.push_back(e);
  endfunction

  function automatic void push_fin(input bit w);
    exp_t e;
    e.is_fin = 1'b1; e.tl = '0; e.tg = '0; e.w = w;
    sbq.push_back(e);
  endfunction

  // Monitor: a finish pulse or the LOAD->PLAY step pops the next expectation.
  logic [2:0] prev_ph = 3'd0;
  logic       prev_fin = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (finish === 1'b1) begin
      chk("finish_single_cycle", prev_fin, 1'b0);
      if (sbq.size() == 0) chk("finish_unexpected", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("finish_expected", 32'(e.is_fin), 1);
        chk("round_win", win, 32'(e.w));
      end
    end else if (win === 1'b1) begin
      chk("win_without_finish", win, 0);
    end
    if (phase === PH_PLAY && prev_ph === PH_LOAD) begin
      if (sbq.size() == 0) chk("load_unexpected", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("load_expected", 32'(e.is_fin), 0);
        chk("load_time_left", time_left, e.tl);
        chk("load_target", target, e.tg);
        chk("load_rescued", rescued, 0);
      end
    end
    prev_fin = finish;
    prev_ph  = phase;
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic r, input logic t, input logic h);
    rescue = r; tick = t; hit = h;
    cyc();
    rescue = 1'b0; tick = 1'b0; hit = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_phase_load", phase, PH_LOAD);
    chk("start_tracker_rst", tracker_rst_n, 0);
  endtask

  task automatic wait_phase(input logic [2:0] p, input string nm);
    int n = 0;
    while (phase !== p && n < 200) begin
      cyc();
      n++;
    end
    chk(nm, phase, p);
  endtask

  task automatic check_reset_state();
    chk("rst_phase", phase, PH_IDLE);
    chk("rst_finish", finish, 0);
    chk("rst_win", win, 0);
    chk("rst_tracker_rst", tracker_rst_n, 0);
    chk("rst_time_left", time_left, 0);
    chk("rst_rescued", rescued, 0);
    chk("rst_target", target, 0);
  endtask

  initial begin
    budget_t b;
    reset_n = 1'b0; start = 1'b0; tick = 1'b0; rescue = 1'b0; hit = 1'b0; pause = 1'b0;
    repeat (3) cyc();
    check_reset_state();
    reset_n = 1'b1;
    cyc();
    chk("post_rst_tracker_rst", tracker_rst_n, 1);
    chk("post_rst_idle", phase, PH_IDLE);

    // Level 1 won by two rescues.
    push_load(30, 2);
    do_start();
    cyc();
    chk("play_tracker_rst", tracker_rst_n, 1);
    chk("play_phase", phase, PH_PLAY);
    push_fin(1'b1);
    drive(1, 0, 0);
    drive(1, 0, 0);
    wait_phase(PH_SHOW, "r1_show");
    chk("r1_level", m_lvl, 2);
    push_load(28, 3);
    wait_phase(PH_PLAY, "r2_play");

    // Level 2 lost on timeout after one rescue.
    drive(1, 0, 0);
    chk("r2_rescued", rescued, 1);
    drive(0, 1, 0);
    chk("r2_tick_dec", time_left, 27);
    push_fin(1'b0);
    repeat (27) drive(0, 1, 0);
    wait_phase(PH_SHOW, "r2_show");
    chk("r2_life", m_life, 2);
    chk("r2_level_kept", m_lvl, 2);
    push_load(28, 3);
    wait_phase(PH_PLAY, "r3_play");

    // Completing rescue on the final tick wins.
    drive(1, 0, 0);
    drive(1, 0, 0);
    repeat (27) drive(0, 1, 0);
    chk("r3_last_second", time_left, 1);
    push_fin(1'b1);
    drive(1, 1, 0);
    push_load(26, 4);
    wait_phase(PH_PLAY, "r4_play");

    // Hit with a completing rescue loses and does not count the rescue.
    repeat (3) drive(1, 0, 0);
    push_fin(1'b0);
    drive(1, 0, 1);
    chk("r4_result_phase", phase, PH_RESULT);
    chk("r4_rescued_held", rescued, 3);
    push_load(26, 4);
    wait_phase(PH_PLAY, "r5_play");

    // Win levels 3..10; level 10 loads 12 s, winning it parks in WON.
    for (int lv = 3; lv <= 10; lv++) begin
      push_fin(1'b1);
      for (int k = 0; k < lv + 1; k++) drive(1, 0, 0);
      if (lv < 10) begin
        push_load(30 - 2 * lv, lv + 2);
        wait_phase(PH_PLAY, "win_loop_play");
      end
    end
    wait_phase(PH_WON, "won_phase");
    repeat (3) begin
      drive(1, 1, 1);
      chk("won_ignores_inputs", phase, PH_WON);
    end

    // Fresh game, three hits -> OVER, then restart.
    reset_n = 1'b0;
    cyc();
    check_reset_state();
    reset_n = 1'b1;
    cyc();
    push_load(30, 2);
    do_start();
    wait_phase(PH_PLAY, "g2_play");
    for (int i = 0; i < 3; i++) begin
      push_fin(1'b0);
      drive(0, 0, 1);
      if (i < 2) begin
        push_load(30, 2);
        wait_phase(PH_PLAY, "g2_loss_play");
      end
    end
    wait_phase(PH_OVER, "over_phase");
    chk("over_life", m_life, 0);
    push_load(30, 2);
    do_start();
    wait_phase(PH_PLAY, "g3_play");
    chk("g3_life", m_life, 3);
    chk("g3_level", m_lvl, 1);

`ifdef ROUND_PAUSE_EN
    pause = 1'b1; cyc(); pause = 1'b0;
    repeat (5) drive(1, 1, 0);
    chk("paused_time_left", time_left, 30);
    chk("paused_rescued", rescued, 0);
    chk("paused_phase", phase, PH_PLAY);
    pause = 1'b1; cyc(); pause = 1'b0;
    drive(0, 1, 0);
    chk("unpaused_tick", time_left, 29);
`else
    pause = 1'b1; cyc(); pause = 1'b0;
    drive(0, 1, 0);
    chk("pause_ignored_tick", time_left, 29);
`endif

    // Reset in the middle of a round.
    reset_n = 1'b0;
    cyc();
    chk("mid_rst_phase", phase, PH_IDLE);
    chk("mid_rst_time_left", time_left, 0);
    chk("mid_rst_target", target, 0);
    reset_n = 1'b1;
    cyc();

    b = round_budget(5'd11, 8'd30, 8'd2, 8'd10, 5'd2);
    chk("budget_l11_time", b.secs, 10);
    chk("budget_l11_target", b.target, 12);
    b = round_budget(5'd12, 8'd30, 8'd2, 8'd10, 5'd2);
    chk("budget_l12_clamp", b.secs, 10);
    b = round_budget(5'd5, 8'd14, 8'd2, 8'd10, 5'd2);
    chk("budget_base14_l5_clamp", b.secs, 10);
    b = round_budget(5'd3, 8'd14, 8'd2, 8'd10, 5'd2);
    chk("budget_base14_l3", b.secs, 10);
    b = round_budget(5'd2, 8'd14, 8'd2, 8'd10, 5'd2);
    chk("budget_base14_l2", b.secs, 12);

    repeat (2) cyc();
    chk("scoreboard_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
